// File: rtl/blockchain_cipher_seq.sv
// rtl/blockchain_cipher_seq.sv - sequential CBC encipher over a shared 16-bit/20-bit-key PRESENT core

// Combinational PRESENT variant: 16-bit block, 20-bit key, 4 rounds plus a final whitening key.
module present_cipher (
  input  logic [15:0] pt,
  input  logic [19:0] key,
  output logic [15:0] ct
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  // Substitution on every nibble, then the PRESENT bit permutation (bit i -> 4i mod 15, bit 15 fixed).
  function automatic logic [15:0] sub_perm(input logic [15:0] s);
    logic [15:0] t;
    logic [15:0] o;
    for (int n = 0; n < 4; n++) t[4*n +: 4] = sbox(s[4*n +: 4]);
    o = '0;
    for (int i = 0; i < 15; i++) o[(i*4) % 15] = t[i];
    o[15] = t[15];
    return o;
  endfunction

  // Key schedule step: rotate left by 13, substitute the top nibble, fold in the round counter.
  function automatic logic [19:0] key_next(input logic [19:0] k, input logic [3:0] rc);
    logic [19:0] r;
    r = {k[6:0], k[19:7]};
    r[19:16] = sbox(r[19:16]);
    r[3:0] = r[3:0] ^ rc;
    return r;
  endfunction

  logic [15:0] st;
  logic [19:0] rk;

  // Unrolled rounds; round key is the top 16 bits of the key register.
  always_comb begin
    st = pt;
    rk = key;
    for (int r = 1; r <= 4; r++) begin
      st = sub_perm(st ^ rk[19:4]);
      rk = key_next(rk, 4'(r));
    end
    ct = st ^ rk[19:4];
  end

endmodule

module blockchain_cipher_seq #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              init_vec,
  input  logic [19:0]              key,
  input  logic [16*NUM_BLOCKS-1:0] plaintext,
  output logic [16*NUM_BLOCKS-1:0] ciphertext,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOCKS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [15:0]             chain_q, chain_d;
  logic [19:0]             key_q, key_d;
  logic [16*NUM_BLOCKS-1:0] pt_q, pt_d;
  logic [16*NUM_BLOCKS-1:0] ct_q, ct_d;
  logic                    done_q, done_d;

  logic [15:0] blk_in;
  logic [15:0] blk_out;

  // The single shared core works only from registered state, so inputs may change after start.
  assign blk_in = pt_q[{idx_q, 4'h0} +: 16] ^ chain_q;

  present_cipher u_core (
    .pt  (blk_in),
    .key (key_q),
    .ct  (blk_out)
  );

  assign ciphertext = ct_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;

  // Next-state: latch a message on start while idle, then chain one block per clock.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chain_d = chain_q;
    key_d   = key_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pt_d    = plaintext;
          key_d   = key;
          chain_d = init_vec;
          idx_d   = '0;
          ct_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        ct_d[{idx_q, 4'h0} +: 16] = blk_out;
        chain_d = blk_out;
        idx_d   = idx_q + IW'(1);
        // Terminal compare keeps idx wrap-around invisible for non-power-of-two block counts.
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; async reset discards any message in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      chain_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chain_q <= chain_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_blockchain_cipher_seq.sv
// tb/tb_blockchain_cipher_seq.sv - directed and round-trip bench for blockchain_cipher_seq

module tb_blockchain_cipher_seq;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   init_vec;
  logic [19:0]   key;
  logic [127:0]  plaintext;
  logic [127:0]  ciphertext;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  blockchain_cipher_seq #(.NUM_BLOCKS(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .init_vec   (init_vec),
    .key        (key),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int pdest(input int i);
    return (i == 15) ? 15 : (i * 4) % 15;
  endfunction

  function automatic logic [3:0] m_isb(input logic [3:0] x);
    logic [3:0] r = 4'h0;
    for (int j = 0; j < 16; j++) if (SB[j] == x) r = 4'(j);
    return r;
  endfunction

  function automatic logic [79:0] m_rks(input logic [19:0] k0);
    logic [19:0] k = k0;
    logic [79:0] o;
    for (int r = 1; r <= 5; r++) begin
      o[16*(r-1) +: 16] = k[19:4];
      k = {k[6:0], k[19:7]};
      k[19:16] = SB[k[19:16]];
      k[3:0] = k[3:0] ^ 4'(r);
    end
    return o;
  endfunction

  function automatic logic [15:0] m_enc(input logic [15:0] p, input logic [19:0] k);
    logic [79:0] rks = m_rks(k);
    logic [15:0] s = p;
    logic [15:0] t;
    for (int r = 0; r < 4; r++) begin
      s = s ^ rks[16*r +: 16];
      for (int n = 0; n < 4; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
      for (int i = 0; i < 16; i++) s[pdest(i)] = t[i];
    end
    return s ^ rks[64 +: 16];
  endfunction

  function automatic logic [15:0] m_dec(input logic [15:0] c, input logic [19:0] k);
    logic [79:0] rks = m_rks(k);
    logic [15:0] s = c ^ rks[64 +: 16];
    logic [15:0] t;
    for (int r = 3; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) t[i] = s[pdest(i)];
      for (int n = 0; n < 4; n++) s[4*n +: 4] = m_isb(t[4*n +: 4]);
      s = s ^ rks[16*r +: 16];
    end
    return s;
  endfunction

  function automatic logic [127:0] m_cbc(input logic [127:0] p, input logic [19:0] k, input logic [15:0] iv);
    logic [15:0] ch = iv;
    logic [127:0] o;
    for (int i = 0; i < NB; i++) begin
      o[16*i +: 16] = m_enc(p[16*i +: 16] ^ ch, k);
      ch = o[16*i +: 16];
    end
    return o;
  endfunction

  // Start one message and wait (bounded) for done; ends on the negedge where done is high.
  task automatic run_msg(input logic [127:0] p, input logic [19:0] k, input logic [15:0] v,
                         output int lat, output logic b0);
    @(negedge clk);
    plaintext = p; key = k; init_vec = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b0 = busy;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [127:0] pa, pb, exp_ct, rec, cap;
  logic [19:0]  ka;
  logic [15:0]  iva, prev;
  int           lat, ndone, neq;
  logic         b0;

  initial begin
    rst = 1'b1; start = 1'b0; init_vec = '0; key = '0; plaintext = '0;
    repeat (2) @(negedge clk);
    check("reset_ct", ciphertext, '0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    rst = 1'b0;

    // All-zero vector.
    run_msg('0, 20'h00000, 16'h0000, lat, b0);
    check("zero_busy_rise", 128'(b0), 128'd1);
    check("zero_latency", 128'(lat), 128'(NB));
    check("zero_ct", ciphertext, m_cbc('0, 20'h0, 16'h0));
    check("zero_blk0", 128'(ciphertext[15:0]), 128'(m_enc(16'h0000, 20'h0)));
    check("zero_blk1", 128'(ciphertext[31:16]), 128'(m_enc(ciphertext[15:0], 20'h0)));
    @(negedge clk);
    check("zero_done_pulse", 128'(done), 128'd0);
    check("zero_busy_fall", 128'(busy), 128'd0);

    // Identical-block diffusion.
    pa = {8{16'hABCD}};
    run_msg(pa, 20'h12345, 16'h5A5A, lat, b0);
    check("abcd_latency", 128'(lat), 128'(NB));
    check("abcd_ct", ciphertext, m_cbc(pa, 20'h12345, 16'h5A5A));
    neq = 0;
    for (int i = 0; i < NB - 1; i++) if (ciphertext[16*i +: 16] == ciphertext[16*(i+1) +: 16]) neq++;
    check("abcd_adjacent_equal", 128'(neq), 128'd0);

    // Start while busy: pulses at RUN cycles 2 and 5 with a different message are ignored.
    pa = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    pb = 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444;
    @(negedge clk);
    plaintext = pa; key = 20'hF0E1D; init_vec = 16'h1357; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; cap = '0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin ndone++; cap = ciphertext; end
      start = (c == 2 || c == 5);
      if (c == 2 || c == 5) begin plaintext = pb; key = 20'h0BEEF; init_vec = 16'hFFFF; end
    end
    start = 1'b0;
    check("busy_start_done_count", 128'(ndone), 128'd1);
    check("busy_start_ct", cap, m_cbc(pa, 20'hF0E1D, 16'h1357));
    check("busy_start_ct_hold", ciphertext, m_cbc(pa, 20'hF0E1D, 16'h1357));

    // Reset mid-run after block 3 is written.
    pa = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    @(negedge clk);
    plaintext = pa; key = 20'h2468A; init_vec = 16'hC0DE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    exp_ct = m_cbc(pa, 20'h2468A, 16'hC0DE);
    exp_ct[127:64] = '0;
    check("partial_ct", ciphertext, exp_ct);
    rst = 1'b1;
    #1;
    check("midrst_ct", ciphertext, '0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 128'(ndone), 128'd0);
    run_msg(pa, 20'h2468A, 16'hC0DE, lat, b0);
    check("after_rst_latency", 128'(lat), 128'(NB));
    check("after_rst_ct", ciphertext, m_cbc(pa, 20'h2468A, 16'hC0DE));

    // Back-to-back with start held high.
    pa = 128'hAAAA_5555_AAAA_5555_0F0F_F0F0_1234_8765;
    pb = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
    @(negedge clk);
    plaintext = pa; key = 20'h13579; init_vec = 16'h2468; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 30);
    check("b2b_first_ct", ciphertext, m_cbc(pa, 20'h13579, 16'h2468));
    plaintext = pb; key = 20'hABCDE; init_vec = 16'h0F0F;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("b2b_busy_restart", 128'(busy), 128'd1);
        check("b2b_ct_cleared", ciphertext, '0);
      end
    end while (!done && lat < 30);
    start = 1'b0;
    check("b2b_period", 128'(lat), 128'(NB + 1));
    check("b2b_second_ct", ciphertext, m_cbc(pb, 20'hABCDE, 16'h0F0F));

    // Round trip with an independent decipher.
    for (int t = 0; t < 200; t++) begin
      pa  = {$urandom, $urandom, $urandom, $urandom};
      ka  = 20'($urandom);
      iva = 16'($urandom);
      run_msg(pa, ka, iva, lat, b0);
      prev = iva;
      for (int i = 0; i < NB; i++) begin
        rec[16*i +: 16] = m_dec(ciphertext[16*i +: 16], ka) ^ prev;
        prev = ciphertext[16*i +: 16];
      end
      check("round_trip", rec, pa);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
